ts_pack_arbiter: RTL and testbench
==================================

Name: ts_pack_arbiter

Overview:
- Controller that sequences and shares the 10-bit-in / 32-bit-word packing buffer between two requesters: a TS capture writer and a playback reader.
- Issues single-cycle write/read commands to the buffer and respects the buffer's command recovery time.
- Tracks occupancy in 10-bit slots and blocks writes when full and reads when empty.
- Sits between the TS capture/playback logic and the packing buffer instance.

Parameters:
- DEPTH_WORDS, 32, number of 32-bit buffer words; the buffer's word addresses wrap modulo DEPTH_WORDS.
- SLOTS_PER_WORD, 3, 10-bit slots packed per word.
- CNT_W, 7, width of LEVEL; must hold DEPTH_WORDS*SLOTS_PER_WORD (96).

Ports:
- CLOCK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-high; shared with the buffer.
- WR_REQ  in  1  writer request; held until WR_ACK.
- WR_DATA  in  10  write slot data; sampled in the grant cycle.
- WR_ACK  out  1  one-cycle pulse: write accepted.
- RD_REQ  in  1  reader request; held until RD_ACK.
- RD_ACK  out  1  one-cycle pulse: read accepted.
- RD_DATA  out  10  read slot data; holds its value until the next read.
- RD_VALID  out  1  one-cycle pulse: RD_DATA updated.
- BUF_WRITE  out  1  to buffer WRITE_IN.
- BUF_READ  out  1  to buffer READ_IN.
- BUF_WDATA  out  10  to buffer DATA_IN.
- BUF_RDATA  in  10  from buffer DATA_OUT.
- LEVEL  out  CNT_W  occupied slots.
- FULL  out  1  LEVEL == DEPTH_WORDS*SLOTS_PER_WORD.
- EMPTY  out  1  LEVEL == 0.
- BUSY  out  1  FSM not in IDLE.

Behaviour:
- Reset values: all outputs 0 except EMPTY=1; FSM in IDLE; last_grant = READ, so the first tie goes to write. Reset may arrive at any time; the buffer is reset together with this block, so no re-sync is required.
- FSM states: IDLE, WR_WAIT, RD_WAIT, RD_CAP.
- IDLE, grant cycle G:
  - wr_ok = WR_REQ & !FULL; rd_ok = RD_REQ & !EMPTY.
  - If both are ok, the grant goes opposite to last_grant (round robin).
  - No grant: stay in IDLE, all command outputs 0.
- Write grant at the end of G:
  - Registered: BUF_WRITE=1, BUF_WDATA=WR_DATA, WR_ACK=1, LEVEL+1, last_grant=WRITE, next state WR_WAIT.
  - WR_WAIT lasts 2 cycles (G+1, G+2). BUF_WRITE is high in G+1 only.
  - Return to IDLE in G+3. Maximum write rate: 1 per 3 cycles.
- Read grant at the end of G:
  - Registered: BUF_READ=1, RD_ACK=1, LEVEL-1, last_grant=READ, next state RD_WAIT.
  - RD_WAIT lasts 2 cycles (G+1, G+2). BUF_READ is high in G+1 only.
  - RD_CAP in G+3: RD_DATA<=BUF_RDATA, RD_VALID=1 in G+4, return to IDLE in G+4.
  - Read latency: grant to RD_VALID = 4 cycles.
- Commands are never overlapped; at most one of BUF_WRITE/BUF_READ is high in any cycle.
- FULL and EMPTY are registered and derived from the updated LEVEL in the same edge as the grant.
- A request blocked by FULL or EMPTY is held with no ACK and no error; it is granted once the condition clears.
- A request dropped before its ACK is legal; nothing is issued.
- LEVEL never wraps: it saturates by construction and is never above capacity or below 0.
- Slot order is preserved: reads return slots in write order, including across word-address wrap.

Optional Feature:
- Macro: TS_ARB_WR_PRIORITY_EN.
- Defined: fixed priority; a write always wins when both wr_ok and rd_ok are true (capture must never stall on playback). last_grant is unused.
- Undefined: round-robin tie-break as in Behaviour.

Test Plan:
- Reset, then write 0x155, then read.
  - Required: WR_ACK at G+1, BUF_WRITE at G+1 only, LEVEL=1.
  - Read returns RD_DATA=0x155 with RD_VALID 4 cycles after its grant; EMPTY=1 afterwards.
- Write 96 slots (0..95) with WR_REQ held high.
  - Required: FULL=1 after the 96th grant; the 97th request gets no WR_ACK until one read completes.
  - Reads then return 0..95 in order, through the address wrap.
- RD_REQ from reset with the buffer empty.
  - Required: no RD_ACK, BUF_READ stays 0; after one write, the read is granted.
- WR_REQ and RD_REQ held high with LEVEL=10.
  - Required (macro off): grants alternate W,R,W,R starting with W.
  - Required (macro on): all grants are W until FULL.
- RESET asserted in WR_WAIT.
  - Required: immediately BUF_WRITE=0, LEVEL=0, EMPTY=1, state IDLE.
  - A post-reset write/read of 0x2AA round-trips correctly.

Source files
------------

// File: rtl/ts_pack_arbiter_if.sv
// Handshake and buffer-command bundle between the TS writer/reader, the
// ts_pack_arbiter and the 10-bit/32-bit packing buffer.
interface ts_pack_arbiter_if #(
  parameter int unsigned CNT_W = 7
) ();
  localparam int unsigned SLOT_W = 10;

  logic              WR_REQ;
  logic [SLOT_W-1:0] WR_DATA;
  logic              WR_ACK;
  logic              RD_REQ;
  logic              RD_ACK;
  logic [SLOT_W-1:0] RD_DATA;
  logic              RD_VALID;
  logic              BUF_WRITE;
  logic              BUF_READ;
  logic [SLOT_W-1:0] BUF_WDATA;
  logic [SLOT_W-1:0] BUF_RDATA;
  logic [CNT_W-1:0]  LEVEL;
  logic              FULL;
  logic              EMPTY;
  logic              BUSY;

  // Arbiter side
  modport slave (
    input  WR_REQ, WR_DATA, RD_REQ, BUF_RDATA,
    output WR_ACK, RD_ACK, RD_DATA, RD_VALID,
           BUF_WRITE, BUF_READ, BUF_WDATA, LEVEL, FULL, EMPTY, BUSY
  );

  // Requester / buffer side
  modport master (
    output WR_REQ, WR_DATA, RD_REQ, BUF_RDATA,
    input  WR_ACK, RD_ACK, RD_DATA, RD_VALID,
           BUF_WRITE, BUF_READ, BUF_WDATA, LEVEL, FULL, EMPTY, BUSY
  );
endinterface

// File: rtl/ts_pack_arbiter.sv
// Shares the 10-bit-slot packing buffer between the TS capture writer and the
// playback reader. Define TS_ARB_WR_PRIORITY_EN for fixed write priority.
module ts_pack_arbiter #(
  parameter int unsigned DEPTH_WORDS    = 32,
  parameter int unsigned SLOTS_PER_WORD = 3,
  parameter int unsigned CNT_W          = 7
) (
  input logic              CLOCK,
  input logic              RESET,
  ts_pack_arbiter_if.slave bus
);
  localparam int unsigned SLOT_W = 10;
  localparam int unsigned CAP    = DEPTH_WORDS * SLOTS_PER_WORD;
  localparam logic [CNT_W-1:0] CAP_L = CNT_W'(CAP);

  typedef enum logic [1:0] {IDLE, WR_WAIT, RD_WAIT, RD_CAP} state_t;

  state_t             state_q;
  logic               hold_q;
  logic [CNT_W-1:0]   level_q;
  logic               full_q;
  logic               empty_q;
  logic               busy_q;
  logic               wr_ack_q;
  logic               rd_ack_q;
  logic               rd_valid_q;
  logic [SLOT_W-1:0]  rd_data_q;
  logic               buf_write_q;
  logic               buf_read_q;
  logic [SLOT_W-1:0]  buf_wdata_q;
  logic [CNT_W-1:0]   level_inc_d;
  logic [CNT_W-1:0]   level_dec_d;
  logic               wr_ok;
  logic               rd_ok;
  logic               grant_wr;
  logic               grant_rd;

  assign level_inc_d = level_q + CNT_W'(1);
  assign level_dec_d = level_q - CNT_W'(1);

  // FULL/EMPTY gate the requests so LEVEL can never leave 0..CAP
  assign wr_ok = bus.WR_REQ & ~full_q;
  assign rd_ok = bus.RD_REQ & ~empty_q;

`ifdef TS_ARB_WR_PRIORITY_EN
  assign grant_wr = wr_ok;
`else
  logic last_rd_q;  // 1: last grant went to the reader
  assign grant_wr = wr_ok & (~rd_ok | last_rd_q);
`endif
  assign grant_rd = rd_ok & ~grant_wr;

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      hold_q      <= 1'b0;
      level_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      busy_q      <= 1'b0;
      wr_ack_q    <= 1'b0;
      rd_ack_q    <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      buf_write_q <= 1'b0;
      buf_read_q  <= 1'b0;
      buf_wdata_q <= '0;
`ifndef TS_ARB_WR_PRIORITY_EN
      last_rd_q   <= 1'b1;
`endif
    end else begin
      // Single-cycle pulses by default
      wr_ack_q    <= 1'b0;
      rd_ack_q    <= 1'b0;
      rd_valid_q  <= 1'b0;
      buf_write_q <= 1'b0;
      buf_read_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_wr) begin
            buf_write_q <= 1'b1;
            buf_wdata_q <= bus.WR_DATA;
            wr_ack_q    <= 1'b1;
            level_q     <= level_inc_d;
            full_q      <= (level_inc_d == CAP_L);
            empty_q     <= 1'b0;
            hold_q      <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= WR_WAIT;
`ifndef TS_ARB_WR_PRIORITY_EN
            last_rd_q   <= 1'b0;
`endif
          end else if (grant_rd) begin
            buf_read_q  <= 1'b1;
            rd_ack_q    <= 1'b1;
            level_q     <= level_dec_d;
            full_q      <= 1'b0;
            empty_q     <= (level_dec_d == '0);
            hold_q      <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= RD_WAIT;
`ifndef TS_ARB_WR_PRIORITY_EN
            last_rd_q   <= 1'b1;
`endif
          end
        end
        // Two-cycle command recovery after each buffer command
        WR_WAIT: begin
          hold_q <= ~hold_q;
          if (hold_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        RD_WAIT: begin
          hold_q <= ~hold_q;
          if (hold_q) state_q <= RD_CAP;
        end
        RD_CAP: begin
          rd_data_q  <= bus.BUF_RDATA;
          rd_valid_q <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.WR_ACK    = wr_ack_q;
  assign bus.RD_ACK    = rd_ack_q;
  assign bus.RD_DATA   = rd_data_q;
  assign bus.RD_VALID  = rd_valid_q;
  assign bus.BUF_WRITE = buf_write_q;
  assign bus.BUF_READ  = buf_read_q;
  assign bus.BUF_WDATA = buf_wdata_q;
  assign bus.LEVEL     = level_q;
  assign bus.FULL      = full_q;
  assign bus.EMPTY     = empty_q;
  assign bus.BUSY      = busy_q;
endmodule

// File: tb/tb_ts_pack_arbiter.sv
// Scoreboard bench for ts_pack_arbiter: a cycle-level reference model queues
// expected grants and read data; a monitor pops them when the DUT responds.
module tb_ts_pack_arbiter;
  localparam int CAP = 96;
`ifdef TS_ARB_WR_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic CLOCK;
  logic RESET;
  ts_pack_arbiter_if #(.CNT_W(7)) bus ();

  ts_pack_arbiter #(.DEPTH_WORDS(32), .SLOTS_PER_WORD(3), .CNT_W(7)) dut (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  initial begin
    CLOCK = 1'b0;
    forever #5 CLOCK = ~CLOCK;
  end

  int n_chk  = 0;
  int n_fail = 0;
  int n      = 0;
  always @(posedge CLOCK) n <= n + 1;

  function automatic void chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, n);
    end
  endfunction

  // Packing buffer: 32 words x 3 slots, flat slot ring, registered read data
  logic [9:0] bslot [CAP];
  int bw, br;
  always @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      bw <= 0; br <= 0; bus.BUF_RDATA <= '0;
    end else begin
      if (bus.BUF_WRITE) begin bslot[bw] <= bus.BUF_WDATA; bw <= (bw + 1) % CAP; end
      if (bus.BUF_READ)  begin bus.BUF_RDATA <= bslot[br]; br <= (br + 1) % CAP; end
    end
  end

  // Reference model state
  typedef struct { bit is_wr; int cyc; } ack_t;
  typedef struct { logic [9:0] d; int cyc; } rd_t;
  ack_t       ack_q [$];
  rd_t        rd_q  [$];
  logic [9:0] mfifo [$];
  int         mcount, nfree, wr_g, rd_g;
  bit         last_was_wr;
  logic [9:0] wr_g_data;

  // Model: checks level/flags/commands, then decides this cycle's grant
  always @(negedge CLOCK) begin
    bit wr_ok, rd_ok, do_w;
    if (RESET) begin
      mcount = 0; nfree = 0; wr_g = -10; rd_g = -10; last_was_wr = 1'b0;
      ack_q.delete(); rd_q.delete(); mfifo.delete();
    end else begin
      chk("level", int'(bus.LEVEL), mcount);
      chk("full",  int'(bus.FULL),  int'(mcount == CAP));
      chk("empty", int'(bus.EMPTY), int'(mcount == 0));
      chk("busy",  int'(bus.BUSY),  int'(n < nfree));
      chk("buf_write", int'(bus.BUF_WRITE), int'(n == wr_g + 1));
      chk("buf_read",  int'(bus.BUF_READ),  int'(n == rd_g + 1));
      if (n == wr_g + 1) chk("buf_wdata", int'(bus.BUF_WDATA), int'(wr_g_data));
      if (n >= nfree) begin
        wr_ok = bus.WR_REQ && (mcount < CAP);
        rd_ok = bus.RD_REQ && (mcount > 0);
        do_w  = wr_ok && (!rd_ok || PRIO || !last_was_wr);
        if (do_w) begin
          mcount++; mfifo.push_back(bus.WR_DATA);
          wr_g = n; wr_g_data = bus.WR_DATA; nfree = n + 3; last_was_wr = 1'b1;
          ack_q.push_back('{1'b1, n + 1});
        end else if (rd_ok) begin
          mcount--; rd_q.push_back('{mfifo.pop_front(), n + 4});
          rd_g = n; nfree = n + 4; last_was_wr = 1'b0;
          ack_q.push_back('{1'b0, n + 1});
        end
      end
    end
  end

  // Monitor: pops expectations whenever the DUT acknowledges or returns data
  always @(negedge CLOCK) begin
    ack_t e; rd_t r;
    if (!RESET) begin
      if (ack_q.size() > 0 && ack_q[0].cyc < n) begin
        chk("ack_missing", 0, 1); void'(ack_q.pop_front());
      end
      if (bus.WR_ACK || bus.RD_ACK) begin
        chk("ack_exclusive", int'(bus.WR_ACK && bus.RD_ACK), 0);
        if (ack_q.size() == 0) chk("ack_unexpected", 1, 0);
        else begin
          e = ack_q.pop_front();
          chk("ack_kind", int'(bus.WR_ACK), int'(e.is_wr));
          chk("ack_cycle", n, e.cyc);
        end
      end
      if (rd_q.size() > 0 && rd_q[0].cyc < n) begin
        chk("rd_valid_missing", 0, 1); void'(rd_q.pop_front());
      end
      if (bus.RD_VALID) begin
        if (rd_q.size() == 0) chk("rd_valid_unexpected", 1, 0);
        else begin
          r = rd_q.pop_front();
          chk("rd_data", int'(bus.RD_DATA), int'(r.d));
          chk("rd_latency", n, r.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLOCK); #1;
  endtask

  task automatic do_write(input logic [9:0] d);
    int k = 0;
    bus.WR_REQ = 1'b1; bus.WR_DATA = d;
    do begin tick(); k++; end while (!bus.WR_ACK && k < 200);
    if (!bus.WR_ACK) chk("wr_ack_timeout", 0, 1);
    bus.WR_REQ = 1'b0;
  endtask

  task automatic do_read();
    int k = 0;
    bus.RD_REQ = 1'b1;
    do begin tick(); k++; end while (!bus.RD_ACK && k < 200);
    if (!bus.RD_ACK) chk("rd_ack_timeout", 0, 1);
    bus.RD_REQ = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while ((ack_q.size() > 0 || rd_q.size() > 0) && k < 50) begin tick(); k++; end
    chk("drain_timeout", int'(ack_q.size() + rd_q.size()), 0);
  endtask

  task automatic apply_reset();
    bus.WR_REQ = 1'b0; bus.RD_REQ = 1'b0;
    RESET = 1'b1; tick(); tick();
    RESET = 1'b0;
  endtask

  initial begin
    int k, acks, guard;
    bit saw_ack;
    RESET = 1'b1;
    bus.WR_REQ = 1'b0; bus.RD_REQ = 1'b0; bus.WR_DATA = '0;
    tick(); tick();
    chk("rst_wr_ack",    int'(bus.WR_ACK), 0);
    chk("rst_rd_ack",    int'(bus.RD_ACK), 0);
    chk("rst_rd_data",   int'(bus.RD_DATA), 0);
    chk("rst_rd_valid",  int'(bus.RD_VALID), 0);
    chk("rst_buf_write", int'(bus.BUF_WRITE), 0);
    chk("rst_buf_read",  int'(bus.BUF_READ), 0);
    chk("rst_buf_wdata", int'(bus.BUF_WDATA), 0);
    chk("rst_level",     int'(bus.LEVEL), 0);
    chk("rst_full",      int'(bus.FULL), 0);
    chk("rst_empty",     int'(bus.EMPTY), 1);
    chk("rst_busy",      int'(bus.BUSY), 0);
    RESET = 1'b0;
    tick();

    // Single round trip
    do_write(10'h155);
    chk("wr1_level", int'(bus.LEVEL), 1);
    chk("wr1_buf_write", int'(bus.BUF_WRITE), 1);
    tick();
    chk("wr1_buf_write_off", int'(bus.BUF_WRITE), 0);
    do_read();
    drain();
    chk("rt1_data", int'(bus.RD_DATA), 'h155);
    chk("rt1_empty", int'(bus.EMPTY), 1);

    // Fill to capacity with WR_REQ held high
    bus.WR_REQ = 1'b1; bus.WR_DATA = '0; acks = 0; k = 0;
    while (acks < CAP && k < 1000) begin
      tick(); k++;
      if (bus.WR_ACK) begin acks++; bus.WR_DATA = 10'(acks); end
    end
    chk("fill_acks", acks, CAP);
    saw_ack = 1'b0;
    repeat (12) begin tick(); if (bus.WR_ACK) saw_ack = 1'b1; end
    chk("full_flag", int'(bus.FULL), 1);
    chk("full_blocks_write", int'(saw_ack), 0);
    do_read();
    k = 0;
    while (!bus.WR_ACK && k < 50) begin tick(); k++; end
    chk("write_after_read", int'(bus.WR_ACK), 1);
    bus.WR_REQ = 1'b0;
    guard = 0;
    while (mcount > 0 && guard < 200) begin do_read(); guard++; end
    drain();
    chk("fill_empty", int'(bus.EMPTY), 1);

    // Read request while empty stays blocked until a write lands
    apply_reset();
    bus.RD_REQ = 1'b1;
    saw_ack = 1'b0;
    repeat (10) begin tick(); if (bus.RD_ACK || bus.BUF_READ) saw_ack = 1'b1; end
    chk("empty_blocks_read", int'(saw_ack), 0);
    do_write(10'h03C);
    bus.RD_REQ = 1'b1;
    k = 0;
    while (!bus.RD_ACK && k < 50) begin tick(); k++; end
    chk("read_after_write", int'(bus.RD_ACK), 1);
    bus.RD_REQ = 1'b0;
    drain();

    // Tie-break with LEVEL=10 and last grant = read
    for (int i = 0; i < 11; i++) do_write(10'(i + 16));
    do_read();
    drain();
    chk("tie_level", int'(bus.LEVEL), 10);
    bus.WR_REQ = 1'b1; bus.RD_REQ = 1'b1; bus.WR_DATA = 10'h200;
    acks = 0; k = 0;
    while (acks < 12 && k < 200) begin
      tick(); k++;
      if (bus.WR_ACK || bus.RD_ACK) begin
        chk("tie_grant_is_write", int'(bus.WR_ACK), PRIO ? 1 : int'((acks % 2) == 0));
        acks++; bus.WR_DATA = 10'h200 + 10'(acks);
      end
    end
    chk("tie_grants", acks, 12);
    bus.WR_REQ = 1'b0; bus.RD_REQ = 1'b0;
    guard = 0;
    while (mcount > 0 && guard < 200) begin do_read(); guard++; end
    drain();

    // Asynchronous reset while the write command is on the bus
    bus.WR_REQ = 1'b1; bus.WR_DATA = 10'h0F0;
    k = 0;
    do begin tick(); k++; end while (!bus.WR_ACK && k < 50);
    chk("pre_reset_buf_write", int'(bus.BUF_WRITE), 1);
    bus.WR_REQ = 1'b0;
    RESET = 1'b1;
    #1;
    chk("async_buf_write", int'(bus.BUF_WRITE), 0);
    chk("async_level", int'(bus.LEVEL), 0);
    chk("async_empty", int'(bus.EMPTY), 1);
    chk("async_busy", int'(bus.BUSY), 0);
    tick(); tick();
    RESET = 1'b0;
    tick();
    do_write(10'h2AA);
    do_read();
    drain();
    chk("post_reset_data", int'(bus.RD_DATA), 'h2AA);

    // Random traffic with legal request drops
    repeat (3000) begin
      tick();
      if (bus.WR_ACK) bus.WR_REQ = 1'b0;
      if (bus.RD_ACK) bus.RD_REQ = 1'b0;
      if (!bus.WR_REQ && !bus.WR_ACK && ($urandom % 3 == 0)) begin
        bus.WR_REQ = 1'b1; bus.WR_DATA = 10'($urandom);
      end else if (bus.WR_REQ && ($urandom % 16 == 0)) bus.WR_REQ = 1'b0;
      if (!bus.RD_REQ && !bus.RD_ACK && ($urandom % 3 == 0)) bus.RD_REQ = 1'b1;
      else if (bus.RD_REQ && ($urandom % 16 == 0)) bus.RD_REQ = 1'b0;
    end
    bus.WR_REQ = 1'b0; bus.RD_REQ = 1'b0;
    drain();
    guard = 0;
    while (mcount > 0 && guard < 200) begin do_read(); guard++; end
    drain();
    chk("final_empty", int'(bus.EMPTY), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
